// File: rtl/instr_encoder_loader.sv
// RV32I field-level instruction encoder feeding a small FIFO that writes
// encoded words into instruction memory at consecutive word addresses.
module instr_encoder_loader #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_imm,
    output logic              err_fmt,
    output logic              wrapped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_imm_q, err_fmt_q, wrapped_q;

    logic [31:0] enc_word_s;
    logic        enc_bad_imm_s, enc_bad_fmt_s;
    logic        accept_s, pop_s, empty_s, full_s, drain_empty_s;

    assign empty_s  = (count_q == '0);
    assign full_s   = (count_q == FULL_CNT);
    assign accept_s = in_valid && in_ready;
    assign pop_s    = !empty_s && imem_ready;

    assign in_ready   = !full_s && (state_q != DONE);
    assign imem_we    = !empty_s;
    assign imem_wdata = fifo_q[rd_ptr_q];
    assign imem_addr  = addr_q;
    assign busy       = (state_q == LOAD) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign err_imm    = err_imm_q;
    assign err_fmt    = err_fmt_q;
    assign wrapped    = wrapped_q;

    // Pack the descriptor and flag out-of-range or misaligned immediates
    always_comb begin
        enc_word_s    = 32'h0000_0013;
        enc_bad_imm_s = 1'b0;
        enc_bad_fmt_s = 1'b0;
        case (in_fmt)
            3'd0: enc_word_s = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: begin
                enc_word_s    = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_bad_imm_s = (in_imm[31:11] != {21{in_imm[11]}});
            end
            3'd2: begin
                enc_word_s    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_bad_imm_s = (in_imm[31:11] != {21{in_imm[11]}});
            end
            3'd3: begin
                enc_word_s    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], in_opcode};
                enc_bad_imm_s = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
            end
            3'd4: begin
                enc_word_s    = {in_imm[31:12], in_rd, in_opcode};
                enc_bad_imm_s = (in_imm[11:0] != 12'd0);
            end
            3'd5: begin
                enc_word_s    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_bad_imm_s = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
            end
            default: enc_bad_fmt_s = 1'b1;
        endcase
    end

    // Next-state: DONE is entered on the edge where the final word leaves the FIFO
    always_comb begin
        state_d       = state_q;
        drain_empty_s = (empty_s || (pop_s && (count_q == (PTR_W+1)'(1)))) && !accept_s;
        case (state_q)
            IDLE:    state_d = accept_s ? (in_last ? DRAIN : LOAD) : IDLE;
            LOAD:    state_d = (accept_s && in_last) ? DRAIN : LOAD;
            DRAIN:   state_d = drain_empty_s ? DONE : DRAIN;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO, write address and sticky flags; clear drops any same-cycle push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 32'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= BASE_A;
            err_imm_q <= 1'b0;
            err_fmt_q <= 1'b0;
            wrapped_q <= 1'b0;
        end else if (clear) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= BASE_A;
            err_imm_q <= 1'b0;
            err_fmt_q <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            if (accept_s) begin
                fifo_q[wr_ptr_q] <= enc_word_s;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                err_imm_q        <= err_imm_q | enc_bad_imm_s;
                err_fmt_q        <= err_fmt_q | enc_bad_fmt_s;
            end
            if (pop_s) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                addr_q    <= addr_q + ADDR_W'(1);
                wrapped_q <= wrapped_q | (addr_q == {ADDR_W{1'b1}});
            end
            case ({accept_s, pop_s})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
